// File: rtl/ram8_reader_pkg.sv
// Shared types and constants for the RAM8 sequential reader.
package ram8_reader_pkg;
  localparam int         DEPTH     = 8;
  localparam int         ADDR_W    = $clog2(DEPTH);
  localparam logic [3:0] COUNT_MAX = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] sat_count(input logic [3:0] c);
    return (c > COUNT_MAX) ? COUNT_MAX : c;
  endfunction
endpackage

// File: rtl/ram8_reader_register16.sv
// 16-bit load-enabled register with synchronous active-high reset.
module ram8_reader_register16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out
);
  always_ff @(posedge clk) begin
    if (reset)     out <= '0;
    else if (load) out <= in;
  end
endmodule

// File: rtl/ram8_reader.sv
// Sequential wrap-around read master for one RAM8 bank, valid/ready stream out.
// Optional running checksum on the stream enabled by defining RAM8_READER_SUM_EN.
module ram8_reader
  import ram8_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write,
  output logic [15:0]       ram_in,
  input  logic [15:0]       ram_out,
  output logic [15:0]       data,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic [15:0]       sum
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [3:0]        rem;
  logic              fetch;
  logic              accept;

  assign accept      = (state == IDLE) && start;
  assign ram_address = ptr;
  assign ram_write   = 1'b0;
  assign ram_in      = '0;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_comb begin
    state_n = state;
    fetch   = 1'b0;
    case (state)
      IDLE:  if (start) state_n = (sat_count(count) == 4'd0) ? DONE : FETCH;
      FETCH: begin
        fetch   = 1'b1;
        state_n = HOLD;
      end
      HOLD:  if (ready) begin
        if (!last) fetch   = 1'b1;
        else       state_n = DONE;
      end
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        ptr <= base;
        rem <= sat_count(count);
      end
      if (fetch) begin
        ptr   <= ptr + 1'b1;
        rem   <= rem - 1'b1;
        last  <= (rem == 4'd1);
        valid <= 1'b1;
      end else if (state == HOLD && ready && last) begin
        valid <= 1'b0;
      end
    end
  end

  // Word is captured at fetch so later RAM writes cannot disturb a stalled word.
  ram8_reader_register16 u_data (
    .clk   (clk),
    .reset (reset),
    .load  (fetch),
    .in    (ram_out),
    .out   (data)
  );

`ifdef RAM8_READER_SUM_EN
  logic [15:0] acc;
  always_ff @(posedge clk) begin
    if (reset)              acc <= '0;
    else if (accept)        acc <= '0;
    else if (valid && ready) acc <= acc + data;
  end
  assign sum = acc;
`else
  assign sum = 16'h0000;
`endif
endmodule
